calc_engine: RTL
================

CALC_ENGINE -- requirements
Module: calc_engine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK for the clock, RST_N for the reset.
REQ-002 Parameter W, default 4, SHALL set the operand width (legal range 4..16).
REQ-003 Parameter DEB_CYCLES, default 500000, SHALL set the number of stable cycles required for debounce.
REQ-004 Derived localparam NDIG SHALL equal ceil(2W/4), the number of hex digits.
REQ-005 CLK  in  1  system clock.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 X  in  W  operand X (unsynchronised switches, sampled at accept).
REQ-008 Y  in  W  operand Y.
REQ-009 OP  in  2  operation select within the current mode.
REQ-010 KEY  in  2  raw active-low buttons: KEY[0] advances the mode, KEY[1] executes.
REQ-011 MODE  out  2  current mode: 0 arithmetic, 1 logical, 2 comparison, 3 magic.
REQ-012 RESULT  out  2W  registered result.
REQ-013 OVF  out  1  carry or borrow flag.
REQ-014 DIV0  out  1  divide-by-zero flag.
REQ-015 BUSY  out  1  high while an operation is in progress.
REQ-016 DONE  out  1  one-cycle completion pulse.
REQ-017 HEX  out  8*NDIG  active-low 7-segment codes; digit i occupies HEX[8i+7:8i], with bit 7 as the decimal point.

Function
REQ-018 Each KEY bit SHALL pass through a 2-flop synchroniser and a debouncer; the debounced level SHALL change only after DEB_CYCLES consecutive identical synchronised samples.
REQ-019 Each press (debounced 1->0) SHALL produce exactly one single-cycle pulse; a release SHALL produce no pulse.
REQ-020 A mode pulse SHALL increment MODE modulo 4 (3->0 wraps); mode pulses arriving while BUSY=1 SHALL be discarded.
REQ-021 FSM states SHALL be IDLE, CALC, FIN.
REQ-022 An exec pulse in IDLE (cycle t) SHALL latch X, Y, OP and MODE, and enter CALC at t+1; exec pulses outside IDLE SHALL be discarded.
REQ-023 Simultaneous mode and exec pulses in IDLE SHALL both take effect; the operation SHALL use the pre-increment MODE.
REQ-024 BUSY SHALL be 1 in CALC and FIN.
REQ-025 CALC SHALL last 1 cycle for every operation except mode 0 multiply and mode 0 divide with nonzero Y, which SHALL take W cycles.
REQ-026 Multiply SHALL be iterative shift-add; divide SHALL be iterative restoring division.
REQ-027 FIN SHALL last one cycle: DONE=1, and RESULT/OVF/DIV0 update on entry to FIN, then the FSM returns to IDLE.
REQ-028 Single-cycle ops SHALL assert DONE at t+2; multiply/divide SHALL assert DONE at t+W+1.
REQ-029 Mode 0 (arithmetic), OP 00: RESULT = X+Y zero-extended; OVF = carry out of bit W-1.
REQ-030 Mode 0, OP 01: RESULT[W-1:0] = (X-Y) mod 2^W, upper bits 0; OVF = 1 when Y>X.
REQ-031 Mode 0, OP 10: RESULT = full 2W-bit product; OVF = 0.
REQ-032 Mode 0, OP 11: RESULT = {remainder, quotient}, W bits each; when Y=0, DIV0=1, RESULT = all ones, and the operation completes as single-cycle.
REQ-033 Mode 1 (logical), OP 00/01/10/11: X&Y, X|Y, X^Y, ~X respectively, each W bits, zero-extended.
REQ-034 Mode 2 (comparison), OP 00: RESULT[2:0] = {X>Y, X==Y, X<Y}.
REQ-035 Mode 2, OP 01/10/11: max(X,Y), min(X,Y), |X-Y| respectively.
REQ-036 Mode 3 (magic): RESULT = 8'h3F zero-extended, independent of OP.
REQ-037 OVF and DIV0 SHALL be 0 for every mode other than 0.
REQ-038 HEX digit i SHALL show RESULT[4i+3:4i] as hex 0-F and SHALL be decoded combinationally from registered RESULT.
REQ-039 All decimal points SHALL be 1 (off), except digit 0 which SHALL be 0 when OVF or DIV0 is set.

Reset
REQ-040 On RST_N low, asynchronously: MODE=0, RESULT=0, OVF=0, DIV0=0, BUSY=0, DONE=0, FSM=IDLE, debounced levels=released (1), counters=0.
REQ-041 During reset every HEX digit SHALL equal 8'hC0.
REQ-042 Reset asserted mid-operation SHALL abort the operation with no DONE pulse; after release the block SHALL wait for a new press.

Structure
REQ-043 Package calc_pkg SHALL hold the MODE encodings, the OP encodings, the FSM state type and the magic constant.
REQ-044 The sub-module key_debounce (synchroniser, counter, press pulse), parameterised by DEB_CYCLES, SHALL be instantiated twice.
REQ-045 The 7-segment decode SHALL be a function in calc_pkg.

Verification (W=4, DEB_CYCLES=4)
REQ-046 X=9, Y=8, mode 0, OP 00, exec -> DONE at t+2, RESULT=0x11, OVF=1, HEX0 DP=0.
REQ-047 X=13, Y=11, OP 10 -> BUSY for 5 cycles, DONE at t+5, RESULT=0x8F, OVF=0.
REQ-048 X=14, Y=4, OP 11 -> RESULT=0x23; then Y=0 -> DIV0=1, RESULT=0xFF, DONE at t+2.
REQ-049 KEY[0] bouncing every 2 cycles for 10 cycles, then held low -> exactly one MODE increment; four clean presses -> MODE 0->1->2->3->0.
REQ-050 Mode-key press during a multiply -> MODE unchanged; exec press during BUSY -> ignored, only one DONE pulse.
REQ-051 RST_N pulsed low at CALC cycle 2 of a multiply -> all outputs at reset values, no DONE, HEX=0xC0C0.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings, FSM state type, magic constant and 7-segment decoder for calc_engine
package calc_pkg;
    typedef enum logic [1:0] {
        MODE_ARITH = 2'd0,
        MODE_LOGIC = 2'd1,
        MODE_CMP   = 2'd2,
        MODE_MAGIC = 2'd3
    } mode_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIN
    } state_e;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b00;
    localparam logic [1:0] OP_MAX = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [7:0] MAGIC  = 8'h3F;
    // Active-low segments, bit order gfedcba
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises, debounces and edge-detects one raw active-low key
// Ports: clk, rst_n (async active-low), key_n (raw key), press (one-cycle pulse per debounced press)
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [1:0]    sync_q;
    logic          level_q, level_d, press_q, press_d, differ, at_limit;
    logic [CW-1:0] cnt_q, cnt_d;
    assign differ   = sync_q[1] != level_q;
    assign at_limit = cnt_q == CW'(DEB_CYCLES - 1);
    // Counter tracks consecutive samples disagreeing with the level; the level flips on the DEB_CYCLES-th one
    always_comb begin
        level_d = (differ && at_limit) ? sync_q[1] : level_q;
        cnt_d   = (differ && !at_limit) ? cnt_q + 1'b1 : '0;
        press_d = level_q & ~level_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end
    assign press = press_q;
endmodule

// File: rtl/calc_engine.sv
// calc_engine: button-driven 4-mode calculator with iterative multiply/divide and 7-segment output
// Ports: CLK, RST_N (async active-low), X/Y operands, OP select, KEY[1:0] raw active-low buttons
//        (0 = mode, 1 = exec); MODE, RESULT, OVF, DIV0, BUSY, DONE, HEX active-low digits
module calc_engine
    import calc_pkg::*;
#(
    parameter  int W          = 4,
    parameter  int DEB_CYCLES = 500000,
    localparam int NDIG       = (2 * W + 3) / 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [W-1:0]        X,
    input  logic [W-1:0]        Y,
    input  logic [1:0]          OP,
    input  logic [1:0]          KEY,
    output logic [1:0]          MODE,
    output logic [2*W-1:0]      RESULT,
    output logic                OVF,
    output logic                DIV0,
    output logic                BUSY,
    output logic                DONE,
    output logic [8*NDIG-1:0]   HEX
);
    localparam int RW = 2 * W;
    localparam int CW = $clog2(W);
    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d, op_mode_q, op_mode_d, op_q, op_d;
    logic [W-1:0]  x_q, x_d, y_q, y_d, lo;
    logic [RW-1:0] acc_q, acc_d, sh_q, sh_d, result_q, result_d, s_res, mul_acc;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, div0_q, div0_d, busy_q, busy_d, done_q, done_d;
    logic          mode_press, exec_press, iter, s_ovf, s_div0, div_ge;
    logic [W:0]    sum, diff, div_sh, div_rem;
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode_key (
        .clk(CLK), .rst_n(RST_N), .key_n(KEY[0]), .press(mode_press)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exec_key (
        .clk(CLK), .rst_n(RST_N), .key_n(KEY[1]), .press(exec_press)
    );
    assign iter    = op_mode_q == MODE_ARITH && (op_q == OP_MUL || (op_q == OP_DIV && y_q != '0));
    assign sum     = {1'b0, x_q} + {1'b0, y_q};
    assign diff    = {1'b0, x_q} - {1'b0, y_q};
    // Shift-add step: y_q is consumed LSB first while sh_q carries X shifted into place
    assign mul_acc = acc_q + (y_q[0] ? sh_q : '0);
    // Restoring-division step: acc_q holds the partial remainder, x_q shifts dividend out / quotient in
    assign div_sh  = {acc_q[W-1:0], x_q[W-1]};
    assign div_ge  = div_sh >= {1'b0, y_q};
    assign div_rem = div_ge ? div_sh - {1'b0, y_q} : div_sh;
    always_comb begin
        lo     = '0;
        s_res  = '0;
        s_ovf  = 1'b0;
        s_div0 = 1'b0;
        case (op_mode_q)
            MODE_ARITH: begin
                // Only add, subtract and divide-by-zero reach the single-cycle path
                s_res  = op_q == OP_ADD ? RW'(sum) : op_q == OP_SUB ? RW'(diff[W-1:0]) : '1;
                s_ovf  = op_q == OP_ADD ? sum[W] : op_q == OP_SUB && diff[W];
                s_div0 = op_q == OP_DIV;
            end
            MODE_LOGIC: begin
                lo    = op_q == OP_AND ? x_q & y_q : op_q == OP_OR ? x_q | y_q :
                        op_q == OP_XOR ? x_q ^ y_q : ~x_q;
                s_res = RW'(lo);
            end
            MODE_CMP: begin
                lo    = op_q == OP_MAX ? (x_q > y_q ? x_q : y_q) : op_q == OP_MIN ? (x_q < y_q ? x_q : y_q) :
                        (x_q > y_q ? x_q - y_q : y_q - x_q);
                s_res = op_q == OP_CMP ? RW'({x_q > y_q, x_q == y_q, x_q < y_q}) : RW'(lo);
            end
            default: s_res = RW'(MAGIC);
        endcase
    end
    always_comb begin
        state_d   = state_q;
        mode_d    = (mode_press && !busy_q) ? mode_q + 2'd1 : mode_q;
        op_mode_d = op_mode_q;
        op_d      = op_q;
        x_d       = x_q;
        y_d       = y_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        div0_d    = div0_q;
        case (state_q)
            ST_IDLE: if (exec_press) begin
                state_d   = ST_CALC;
                op_mode_d = mode_q;
                op_d      = OP;
                x_d       = X;
                y_d       = Y;
                acc_d     = '0;
                sh_d      = RW'(X);
                cnt_d     = '0;
            end
            ST_CALC: if (!iter) begin
                state_d  = ST_FIN;
                result_d = s_res;
                ovf_d    = s_ovf;
                div0_d   = s_div0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    sh_d  = sh_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = RW'(div_rem);
                    x_d   = {x_q[W-2:0], div_ge};
                end
                if (cnt_q == CW'(W - 1)) begin
                    state_d  = ST_FIN;
                    result_d = op_q == OP_MUL ? mul_acc : {div_rem[W-1:0], x_q[W-2:0], div_ge};
                    ovf_d    = 1'b0;
                    div0_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE;
        done_d = state_d == ST_FIN;
    end
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            mode_q    <= '0;
            op_mode_q <= '0;
            op_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            op_mode_q <= op_mode_d;
            op_q      <= op_d;
            x_q       <= x_d;
            y_q       <= y_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign MODE   = mode_q;
    assign RESULT = result_q;
    assign OVF    = ovf_q;
    assign DIV0   = div0_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    logic [4*NDIG-1:0] res_pad;
    assign res_pad = (4 * NDIG)'(result_q);
    for (genvar i = 0; i < NDIG; i++) begin : g_hex
        assign HEX[8*i+:8] = {i == 0 ? ~(ovf_q | div0_q) : 1'b1, seg7(res_pad[4*i+:4])};
    end
endmodule
